// File: rtl/uart_pkg.sv
// Shared constants and holding-register state type for the UART transmit path.
package uart_pkg;

  localparam logic [3:0]  UART_TX_ADDR    = 4'b0000;
  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    HR_EMPTY,
    HR_LOADED,
    HR_SENDING
  } hr_state_e;

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, producing a registered
// one-cycle pulse on each rising edge of the synchronised level.
module uart_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              rise_q;

  // The pulse registers in the same cycle the last stage goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl_p.sv
// UART transmit FIFO controller: holding register plus a 2**DEPTH_LOG2 FIFO,
// fed by DSP bus writes and drained by the Tx shifter's TxBusy/TxDone handshake.
module uart_tx_fifo_ctrl_p
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = UART_DATA_W,
  parameter int unsigned DEPTH_LOG2  = UART_DEPTH_LOG2,
  parameter logic [3:0]  TX_REG_ADDR = UART_TX_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  DSP_CLK,
  input  logic                  RESETn,
  input  logic                  DSP_CEn,
  input  logic [3:0]            DSP_ADDR,
  input  logic [15:0]           DSP_WDATA,
  input  logic                  DSP_WEn,
  input  logic                  FIFOEn,
  input  logic                  FIFO_Flush,
  input  logic [DEPTH_LOG2:0]   TrigLevel,
  input  logic                  OvfClr,
  input  logic                  TxBusy,
  input  logic                  TxDone,
  output logic                  TxDataReady,
  output logic [DATA_W-1:0]     TxData,
  output logic                  TxFIFO_Empty,
  output logic                  TxFIFO_Full,
  output logic [DEPTH_LOG2:0]   TxFIFO_Level,
  output logic                  TxFIFO_Trig,
  output logic                  TxFIFO_Ovf
);

  localparam int unsigned     PtrW     = DEPTH_LOG2 + 1;
  localparam int unsigned     Entries  = 2 ** DEPTH_LOG2;
  localparam logic [PtrW-1:0] DepthVal = PtrW'(Entries);

  hr_state_e         state_q, state_d;
  logic [DATA_W-1:0] hr_q, hr_d;
  logic [PtrW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem [Entries];

  logic              busy_rise, done_pulse;
  logic [PtrW-1:0]   level;
  logic              wr, fifo_empty, fifo_full;
  logic              hr_done, hr_free, pop, push, hr_wr, ovf_set;
  logic [DATA_W-1:0] wdata;
  logic              unused_wdata;

  uart_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_busy (
    .clk   (DSP_CLK),
    .rst_n (RESETn),
    .din   (TxBusy),
    .rise  (busy_rise)
  );

  uart_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_done (
    .clk   (DSP_CLK),
    .rst_n (RESETn),
    .din   (TxDone),
    .rise  (done_pulse)
  );

  assign wdata        = DSP_WDATA[DATA_W-1:0];
  assign unused_wdata = ^DSP_WDATA[15:DATA_W];

  always_comb begin
    wr         = !DSP_CEn && !DSP_WEn && (DSP_ADDR == TX_REG_ADDR);
    level      = wp_q - rp_q;
    fifo_empty = (level == '0);
    fifo_full  = (level == DepthVal);
  end

  // Write routing: flush swallows the write, then HR, then FIFO, else overflow.
  always_comb begin
    hr_done = done_pulse && (state_q != HR_EMPTY);
    hr_free = (state_q == HR_EMPTY) || (hr_done && fifo_empty);
    pop     = hr_done && !fifo_empty && !FIFO_Flush;
    hr_wr   = wr && !FIFO_Flush && hr_free;
    push    = wr && !FIFO_Flush && !hr_free && FIFOEn && (!fifo_full || pop);
    ovf_set = wr && !FIFO_Flush && !hr_free && !push;
  end

  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= HR_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Done is honoured in HR_LOADED too, so a missed busy edge cannot stall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HR_EMPTY: begin
        if (hr_wr) state_d = HR_LOADED;
      end
      HR_LOADED, HR_SENDING: begin
        if (hr_done) begin
          state_d = (pop || hr_wr) ? HR_LOADED : HR_EMPTY;
        end else if (busy_rise && (state_q == HR_LOADED)) begin
          state_d = HR_SENDING;
        end
      end
      default: state_d = HR_EMPTY;
    endcase
  end

  always_comb begin
    TxDataReady  = (state_q != HR_EMPTY);
    TxData       = hr_q;
    TxFIFO_Empty = fifo_empty;
    TxFIFO_Full  = fifo_full;
    TxFIFO_Level = level;
    TxFIFO_Trig  = (level <= TrigLevel);
    TxFIFO_Ovf   = ovf_q;
  end

  always_comb begin
    hr_d = hr_q;
    if (hr_wr) begin
      hr_d = wdata;
    end else if (pop) begin
      hr_d = mem[rp_q[DEPTH_LOG2-1:0]];
    end else if (hr_done) begin
      hr_d = '0;
    end
  end

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) wp_d = wp_q + 1'b1;
    if (FIFO_Flush) begin
      rp_d = wp_q;
    end else if (pop) begin
      rp_d = rp_q + 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (OvfClr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      hr_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      hr_q  <= hr_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge DSP_CLK) begin
    if (push) mem[wp_q[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl_p.sv
// Self-checking bench: directed vector table, async reset sequence, and a
// randomized run against a queue-based reference model.
module tb_uart_tx_fifo_ctrl_p;

  localparam int DEPTH = 16;
  localparam int S     = 2;

  logic        DSP_CLK = 1'b0;
  logic        RESETn;
  logic        DSP_CEn, DSP_WEn;
  logic [3:0]  DSP_ADDR;
  logic [15:0] DSP_WDATA;
  logic        FIFOEn, FIFO_Flush, OvfClr, TxBusy, TxDone;
  logic [4:0]  TrigLevel;
  logic        TxDataReady, TxFIFO_Empty, TxFIFO_Full, TxFIFO_Trig, TxFIFO_Ovf;
  logic [7:0]  TxData;
  logic [4:0]  TxFIFO_Level;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo_ctrl_p dut (
    .DSP_CLK      (DSP_CLK),
    .RESETn       (RESETn),
    .DSP_CEn      (DSP_CEn),
    .DSP_ADDR     (DSP_ADDR),
    .DSP_WDATA    (DSP_WDATA),
    .DSP_WEn      (DSP_WEn),
    .FIFOEn       (FIFOEn),
    .FIFO_Flush   (FIFO_Flush),
    .TrigLevel    (TrigLevel),
    .OvfClr       (OvfClr),
    .TxBusy       (TxBusy),
    .TxDone       (TxDone),
    .TxDataReady  (TxDataReady),
    .TxData       (TxData),
    .TxFIFO_Empty (TxFIFO_Empty),
    .TxFIFO_Full  (TxFIFO_Full),
    .TxFIFO_Level (TxFIFO_Level),
    .TxFIFO_Trig  (TxFIFO_Trig),
    .TxFIFO_Ovf   (TxFIFO_Ovf)
  );

  always #5 DSP_CLK = ~DSP_CLK;

  typedef enum {OpWr, OpDone, OpFlushWr, OpOvfClr} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       fifoen;
    logic [4:0] trig;
    logic       exp_rdy;
    logic [7:0] exp_data;
    int         exp_level;
    logic       exp_ovf;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {rdy, data, level, empty, full, trig, ovf}
  function automatic logic [31:0] exp_vec(logic rdy, logic [7:0] data, int lvl,
                                          logic [4:0] trig, logic ovf);
    logic [4:0] l5;
    l5 = 5'(lvl);
    return {14'd0, rdy, data, l5, (lvl == 0), (lvl == DEPTH), (lvl <= int'(trig)), ovf};
  endfunction

  function automatic logic [31:0] act_vec();
    return {14'd0, TxDataReady, TxData, TxFIFO_Level, TxFIFO_Empty, TxFIFO_Full,
            TxFIFO_Trig, TxFIFO_Ovf};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={rdy,data,lvl,e,f,t,o}=%05h required=%05h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(op_e op, logic [7:0] d, logic fe, logic [4:0] tr, logic rdy,
                              logic [7:0] ed, int lvl, logic ovf, string name);
    vec_t v;
    v.op = op; v.data = d; v.fifoen = fe; v.trig = tr; v.exp_rdy = rdy;
    v.exp_data = ed; v.exp_level = lvl; v.exp_ovf = ovf; v.name = name;
    return v;
  endfunction

  task automatic go_idle();
    DSP_CEn = 1'b1; DSP_WEn = 1'b1; DSP_ADDR = 4'h0; FIFO_Flush = 1'b0; OvfClr = 1'b0;
  endtask

  task automatic apply_op(input vec_t v);
    @(negedge DSP_CLK);
    FIFOEn = v.fifoen;
    TrigLevel = v.trig;
    case (v.op)
      OpWr, OpFlushWr: begin
        DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_ADDR = 4'h0; DSP_WDATA = {8'hFF, v.data};
        FIFO_Flush = (v.op == OpFlushWr);
        @(posedge DSP_CLK); #1;
        go_idle();
      end
      OpOvfClr: begin
        OvfClr = 1'b1;
        @(posedge DSP_CLK); #1;
        go_idle();
      end
      default: begin
        TxBusy = 1'b1;
        repeat (3) @(negedge DSP_CLK);
        TxDone = 1'b1;
        repeat (4) @(negedge DSP_CLK);
        TxDone = 1'b0; TxBusy = 1'b0;
        repeat (4) @(negedge DSP_CLK);
        @(posedge DSP_CLK); #1;
      end
    endcase
  endtask

  task automatic do_reset();
    go_idle();
    TxBusy = 1'b0; TxDone = 1'b0; FIFOEn = 1'b1; TrigLevel = 5'd16; DSP_WDATA = '0;
    RESETn = 1'b0;
    repeat (3) @(posedge DSP_CLK);
    @(negedge DSP_CLK);
    RESETn = 1'b1;
  endtask

  // Reference model state
  bit         m_valid;
  logic [7:0] m_data;
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         hist[$];

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ovf = 0;
    m_q.delete();
    hist.delete();
    repeat (S + 2) hist.push_back(1'b0);
  endtask

  // One clock edge using the inputs that were present just before it.
  task automatic model_step();
    bit wr_m, done, hr_done, f_empty, hr_free, set;
    wr_m = !DSP_CEn && !DSP_WEn && (DSP_ADDR == 4'h0);
    hist.push_back(TxDone);
    while (hist.size() > S + 2) void'(hist.pop_front());
    // Done acts S edges after TxDone is first sampled high.
    done    = hist[hist.size() - 1 - S] && !hist[hist.size() - 2 - S];
    hr_done = done && m_valid;
    f_empty = (m_q.size() == 0);
    hr_free = !m_valid || (hr_done && f_empty);
    set     = 0;
    if (FIFO_Flush) begin
      if (hr_done) begin m_valid = 0; m_data = '0; end
      m_q.delete();
    end else begin
      if (hr_done) begin
        if (!f_empty) m_data = m_q.pop_front();
        else begin m_valid = 0; m_data = '0; end
      end
      if (wr_m) begin
        if (hr_free) begin m_valid = 1; m_data = DSP_WDATA[7:0]; end
        else if (FIFOEn && m_q.size() < DEPTH) m_q.push_back(DSP_WDATA[7:0]);
        else set = 1;
      end
    end
    if (set) m_ovf = 1;
    else if (OvfClr) m_ovf = 0;
  endtask

  initial begin
    do_reset();
    #1 check("reset_state", act_vec(), exp_vec(0, 8'h00, 0, 5'd16, 0));

    vecs.push_back(mk(OpWr,   8'hA5, 1, 16, 1, 8'hA5, 0, 0, "single_wr"));
    vecs.push_back(mk(OpDone, 8'h00, 1, 16, 0, 8'h00, 0, 0, "single_drain"));
    for (int k = 0; k <= 16; k++)
      vecs.push_back(mk(OpWr, 8'(k), 1, 16, 1, 8'h00, k, 0, "fill_wr"));
    vecs.push_back(mk(OpWr,     8'h11, 1, 16, 1, 8'h00, 16, 1, "overflow_wr"));
    vecs.push_back(mk(OpOvfClr, 8'h00, 1, 16, 1, 8'h00, 16, 0, "ovf_clear"));
    for (int j = 1; j <= 16; j++)
      vecs.push_back(mk(OpDone, 8'h00, 1, 16, 1, 8'(j), 16 - j, 0, "drain_order"));
    vecs.push_back(mk(OpDone, 8'h00, 1, 16, 0, 8'h00, 0, 0, "drain_last"));
    vecs.push_back(mk(OpWr,   8'h20, 1, 4, 1, 8'h20, 0, 0, "trig_hr"));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(OpWr, 8'(8'h20 + k), 1, 4, 1, 8'h20, k, 0, "trig_fill"));
    for (int j = 1; j <= 5; j++)
      vecs.push_back(mk(OpDone, 8'h00, 1, 4, 1, 8'(8'h20 + j), 5 - j, 0, "trig_pop"));
    vecs.push_back(mk(OpDone,   8'h00, 1, 4, 0, 8'h00, 0, 0, "trig_empty"));
    vecs.push_back(mk(OpWr,     8'h77, 1, 16, 1, 8'h77, 0, 0, "nofifo_hr"));
    vecs.push_back(mk(OpWr,     8'h3C, 0, 16, 1, 8'h77, 0, 1, "nofifo_drop"));
    vecs.push_back(mk(OpOvfClr, 8'h00, 0, 16, 1, 8'h77, 0, 0, "nofifo_clr"));
    vecs.push_back(mk(OpDone,   8'h00, 0, 16, 0, 8'h00, 0, 0, "nofifo_done"));
    vecs.push_back(mk(OpWr,     8'h50, 1, 16, 1, 8'h50, 0, 0, "flush_hr"));
    for (int k = 1; k <= 6; k++)
      vecs.push_back(mk(OpWr, 8'(8'h50 + k), 1, 16, 1, 8'h50, k, 0, "flush_fill"));
    vecs.push_back(mk(OpFlushWr, 8'h99, 1, 16, 1, 8'h50, 0, 0, "flush_with_wr"));
    vecs.push_back(mk(OpDone,    8'h00, 1, 16, 0, 8'h00, 0, 0, "flush_done"));

    foreach (vecs[i]) begin
      apply_op(vecs[i]);
      check(vecs[i].name, act_vec(),
            exp_vec(vecs[i].exp_rdy, vecs[i].exp_data, vecs[i].exp_level, vecs[i].trig,
                    vecs[i].exp_ovf));
    end

    // Asynchronous reset with a part-filled FIFO.
    for (int k = 0; k < 10; k++)
      apply_op(mk(OpWr, 8'(8'h60 + k), 1, 16, 1, 8'h60, 0, 0, "async_fill"));
    check("async_prefill", act_vec(), exp_vec(1, 8'h60, 9, 5'd16, 0));
    @(negedge DSP_CLK);
    #2 RESETn = 1'b0;
    #1 check("async_reset", act_vec(), exp_vec(0, 8'h00, 0, 5'd16, 0));
    @(negedge DSP_CLK);
    RESETn = 1'b1;

    // Randomized run: busy write phase, then a draining phase.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge DSP_CLK);
      if ($urandom_range(0, 99) < ((c < 1000) ? 35 : 5)) begin
        DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_ADDR = 4'h0;
      end else begin
        DSP_CEn = 1'($urandom); DSP_WEn = 1'($urandom); DSP_ADDR = 4'($urandom);
      end
      DSP_WDATA  = 16'($urandom);
      FIFO_Flush = ($urandom_range(0, 99) < 3);
      OvfClr     = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 2) FIFOEn = ~FIFOEn;
      TrigLevel  = 5'($urandom_range(0, 16));
      if ($urandom_range(0, 5) == 0) TxDone = ~TxDone;
      TxBusy     = 1'($urandom);
      @(posedge DSP_CLK);
      model_step();
      #1 check("random", act_vec(), exp_vec(m_valid, m_data, m_q.size(), TrigLevel, m_ovf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
